kugelblitz_axil_reg_file: RTL and testbench

KUGELBLITZ_AXIL_REG_FILE -- requirements
Module: kugelblitz_axil_reg_file

---
 rtl/kugelblitz_axil_reg_file_pkg.sv | 11 +
 rtl/kugelblitz_axil_reg_file.sv | 114 +++++++++++
 tb/tb_kugelblitz_axil_reg_file.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/kugelblitz_axil_reg_file_pkg.sv
// Shared constants for the kugelblitz AXI-lite register file.
package kugelblitz_axil_reg_file_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int unsigned KUGELBLITZ_REG_COUNT = 16;

endpackage

// File: rtl/kugelblitz_axil_reg_file.sv
// AXI-lite slave exposing REG_COUNT byte-strobed read/write registers.
// Single-beat, one outstanding transaction per channel; all responses OKAY.
module kugelblitz_axil_reg_file
    import kugelblitz_axil_reg_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned REG_COUNT  = KUGELBLITZ_REG_COUNT
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,

    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,

    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,

    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,

    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);

    localparam int unsigned BYTE_BITS = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_WIDTH = $clog2(REG_COUNT);
    localparam int unsigned RANGE_LSB = BYTE_BITS + IDX_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
    logic                  r_bvalid;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic                  w_aw_in_range;
    logic                  w_ar_in_range;
    logic [IDX_WIDTH-1:0]  w_aw_idx;
    logic [IDX_WIDTH-1:0]  w_ar_idx;
    logic [DATA_WIDTH-1:0] w_wmask;
    logic                  w_unused_bits;

    // Handshakes: one transaction in flight per channel, never during reset.
    assign w_wr_accept = s_axil_awvalid & s_axil_wvalid & ~r_bvalid & ~rst;
    assign w_rd_accept = s_axil_arvalid & ~r_rvalid & ~rst;

    assign s_axil_awready = w_wr_accept;
    assign s_axil_wready  = w_wr_accept;
    assign s_axil_arready = w_rd_accept;

    assign w_aw_idx      = s_axil_awaddr[BYTE_BITS +: IDX_WIDTH];
    assign w_ar_idx      = s_axil_araddr[BYTE_BITS +: IDX_WIDTH];
    assign w_aw_in_range = (s_axil_awaddr[ADDR_WIDTH-1:RANGE_LSB] == '0);
    assign w_ar_in_range = (s_axil_araddr[ADDR_WIDTH-1:RANGE_LSB] == '0);

    // Protection bits and sub-word address bits carry no meaning here.
    assign w_unused_bits = ^{s_axil_awprot, s_axil_arprot,
                             s_axil_awaddr[BYTE_BITS-1:0], s_axil_araddr[BYTE_BITS-1:0]};

    for (genvar g = 0; g < STRB_WIDTH; g++) begin : g_wmask
        assign w_wmask[g*8 +: 8] = {8{s_axil_wstrb[g]}};
    end

    // Write path: register update and write response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bvalid <= 1'b0;
            r_regs   <= '{default: '0};
        end else begin
            if (w_wr_accept) begin
                r_bvalid <= 1'b1;
            end else if (s_axil_bready) begin
                r_bvalid <= 1'b0;
            end
            if (w_wr_accept && w_aw_in_range) begin
                r_regs[w_aw_idx] <= (r_regs[w_aw_idx] & ~w_wmask) | (s_axil_wdata & w_wmask);
            end
        end
    end

    // Read path: samples the pre-write register value on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_rd_accept) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_ar_in_range ? r_regs[w_ar_idx] : '0;
        end else if (s_axil_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign s_axil_bvalid = r_bvalid;
    assign s_axil_bresp  = AXI_RESP_OKAY;
    assign s_axil_rvalid = r_rvalid;
    assign s_axil_rdata  = r_rdata;
    assign s_axil_rresp  = AXI_RESP_OKAY;

endmodule

// File: tb/tb_kugelblitz_axil_reg_file.sv
// Self-checking bench for kugelblitz_axil_reg_file: vector table plus read scoreboard.
module tb_kugelblitz_axil_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_axil_awaddr;
    logic [2:0]  s_axil_awprot;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;
    logic [31:0] s_axil_araddr;
    logic [2:0]  s_axil_arprot;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;

    always #5 clk = ~clk;

    kugelblitz_axil_reg_file dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awprot  (s_axil_awprot),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arprot  (s_axil_arprot),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] rd_q[$];
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_event(input string name);
        n_total++;
        $display("FAIL %s: got no handshake, expected one within the cycle budget", name);
    endtask

    function automatic vec_t mkv(bit wr, logic [31:0] addr, logic [31:0] data,
                                 logic [3:0] strb, logic [31:0] exp);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.exp = exp;
        return v;
    endfunction

    // Scoreboard: pop one expected word per completed read beat.
    always @(negedge clk) begin
        if (!rst && s_axil_rvalid && s_axil_rready) begin
            if (rd_q.size() == 0) begin
                n_total++;
                $display("FAIL rd_unexpected: got rvalid with data 0x%0h, expected no read", s_axil_rdata);
            end else begin
                check("rdata", {32'h0, s_axil_rdata}, {32'h0, rd_q.pop_front()});
                check("rresp", {62'h0, s_axil_rresp}, 64'h0);
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic axil_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit acc = 1'b0;
        s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = strb;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge clk);
            if (s_axil_awready && s_axil_wready) acc = 1'b1;
        end
        if (!acc) fail_event("wr_accept");
        else check("wr_bvalid_at_accept", {63'h0, s_axil_bvalid}, 64'h0);
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        if (!acc) return;
        @(negedge clk);
        check("wr_bvalid_latency", {63'h0, s_axil_bvalid}, 64'h1);
        check("bresp", {62'h0, s_axil_bresp}, 64'h0);
        @(posedge clk); #1;
    endtask

    task automatic axil_read(input logic [31:0] addr, input logic [31:0] exp);
        bit acc = 1'b0;
        s_axil_araddr = addr; s_axil_arvalid = 1'b1;
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge clk);
            if (s_axil_arready) acc = 1'b1;
        end
        if (!acc) fail_event("rd_accept");
        else rd_q.push_back(exp);
        @(posedge clk); #1;
        s_axil_arvalid = 1'b0;
        if (!acc) return;
        @(negedge clk);
        check("rd_rvalid_latency", {63'h0, s_axil_rvalid}, 64'h1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_ar;
        int n_aw;

        rst = 1'b1;
        s_axil_awaddr = '0; s_axil_awprot = 3'b111; s_axil_wdata = '0; s_axil_wstrb = '0;
        s_axil_araddr = '0; s_axil_arprot = 3'b101;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
        s_axil_bready = 1'b1; s_axil_rready = 1'b1;

        vecs.push_back(mkv(1, 32'h08,  32'hDEADBEEF, 4'hF, 32'h0));
        vecs.push_back(mkv(0, 32'h08,  32'h0,        4'h0, 32'hDEADBEEF));
        vecs.push_back(mkv(1, 32'h08,  32'h11223344, 4'h5, 32'h0));
        vecs.push_back(mkv(0, 32'h08,  32'h0,        4'h0, 32'hDE22BE44));
        vecs.push_back(mkv(1, 32'h0B,  32'h000000AA, 4'h1, 32'h0));
        vecs.push_back(mkv(0, 32'h0A,  32'h0,        4'h0, 32'hDE22BEAA));
        vecs.push_back(mkv(1, 32'h100, 32'hA5A5A5A5, 4'hF, 32'h0));
        vecs.push_back(mkv(0, 32'h100, 32'h0,        4'h0, 32'h0));
        vecs.push_back(mkv(0, 32'h00,  32'h0,        4'h0, 32'h0));
        vecs.push_back(mkv(1, 32'h3C,  32'h12345678, 4'hF, 32'h0));
        vecs.push_back(mkv(0, 32'h3C,  32'h0,        4'h0, 32'h12345678));
        vecs.push_back(mkv(1, 32'h3C,  32'hFFFFFFFF, 4'h0, 32'h0));
        vecs.push_back(mkv(0, 32'h3C,  32'h0,        4'h0, 32'h12345678));
        vecs.push_back(mkv(1, 32'h40,  32'hCAFEF00D, 4'hF, 32'h0));
        vecs.push_back(mkv(0, 32'h00,  32'h0,        4'h0, 32'h0));
        vecs.push_back(mkv(0, 32'h40,  32'h0,        4'h0, 32'h0));
        vecs.push_back(mkv(1, 32'h04,  32'h55AA55AA, 4'hA, 32'h0));
        vecs.push_back(mkv(0, 32'h04,  32'h0,        4'h0, 32'h55005500));
        vecs.push_back(mkv(0, 32'h08,  32'h0,        4'h0, 32'hDE22BEAA));

        // Reset state with requests pending: no ready, no responses.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {61'h0, s_axil_awready, s_axil_wready, s_axil_arready}, 64'h0);
        check("rst_valid", {62'h0, s_axil_bvalid, s_axil_rvalid}, 64'h0);
        check("rst_rdata", {32'h0, s_axil_rdata}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;

        for (int i = 0; i < 16; i++) axil_read(32'(i * 4), 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) axil_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            else            axil_read(vecs[i].addr, vecs[i].exp);
        end

        // Same-cycle read and write of one register: read sees the old value.
        s_axil_awaddr = 32'h08; s_axil_wdata = 32'h0BADF00D; s_axil_wstrb = 4'hF;
        s_axil_araddr = 32'h08;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
        @(negedge clk);
        check("collide_accept", {61'h0, s_axil_awready, s_axil_wready, s_axil_arready}, 64'h7);
        rd_q.push_back(32'hDE22BEAA);
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        @(negedge clk);
        check("collide_bvalid", {63'h0, s_axil_bvalid}, 64'h1);
        @(posedge clk); #1;
        axil_read(32'h08, 32'h0BADF00D);

        // Address ahead of data, then a held-off write response blocks a second write.
        s_axil_awaddr = 32'h0C; s_axil_wdata = 32'h01020304; s_axil_wstrb = 4'hF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("aw_wait_no_ready", {62'h0, s_axil_awready, s_axil_wready}, 64'h0);
            @(posedge clk); #1;
        end
        s_axil_wvalid = 1'b1; s_axil_bready = 1'b0;
        @(negedge clk);
        check("aw_join_accept", {62'h0, s_axil_awready, s_axil_wready}, 64'h3);
        @(posedge clk); #1;
        s_axil_awaddr = 32'h10; s_axil_wdata = 32'h0A0B0C0D;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bhold_bvalid", {63'h0, s_axil_bvalid}, 64'h1);
            check("bhold_stall", {62'h0, s_axil_awready, s_axil_wready}, 64'h0);
            @(posedge clk); #1;
        end
        s_axil_bready = 1'b1;
        @(negedge clk);
        check("bhold_release_stall", {62'h0, s_axil_awready, s_axil_wready}, 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("second_wr_accept", {61'h0, s_axil_awready, s_axil_wready, s_axil_bvalid}, 64'h6);
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        @(negedge clk);
        check("second_wr_bvalid", {63'h0, s_axil_bvalid}, 64'h1);
        @(posedge clk); #1;
        axil_read(32'h0C, 32'h01020304);
        axil_read(32'h10, 32'h0A0B0C0D);

        // Held requests on both channels: one accept each every two cycles.
        n_ar = 0; n_aw = 0;
        s_axil_araddr = 32'h3C; s_axil_arvalid = 1'b1;
        s_axil_awaddr = 32'h14; s_axil_wdata = 32'h00000077; s_axil_wstrb = 4'h1;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (s_axil_arready) begin n_ar++; rd_q.push_back(32'h12345678); end
            if (s_axil_awready && s_axil_wready) n_aw++;
            @(posedge clk); #1;
        end
        s_axil_arvalid = 1'b0; s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        check("rd_throughput", 64'(n_ar), 64'd4);
        check("wr_throughput", 64'(n_aw), 64'd4);
        @(posedge clk); #1;
        axil_read(32'h14, 32'h00000077);

        // Reset with both responses pending drops them and clears registers.
        s_axil_bready = 1'b0; s_axil_rready = 1'b0;
        s_axil_awaddr = 32'h08; s_axil_wdata = 32'hFFFFFFFF; s_axil_wstrb = 4'hF;
        s_axil_araddr = 32'h08;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
        @(negedge clk);
        check("pre_rst_accept", {61'h0, s_axil_awready, s_axil_wready, s_axil_arready}, 64'h7);
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_pending", {62'h0, s_axil_bvalid, s_axil_rvalid}, 64'h3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_dropped", {62'h0, s_axil_bvalid, s_axil_rvalid}, 64'h0);
        check("mid_rst_rdata", {32'h0, s_axil_rdata}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0; s_axil_bready = 1'b1; s_axil_rready = 1'b1;
        axil_read(32'h08, 32'h0);
        axil_read(32'h3C, 32'h0);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 64'(rd_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
